// File: rtl/unidade_load_store.sv
// Load/store unit between the CPU and a registered-read data RAM.
// Latches one request, range-checks it, runs a write or a two-cycle read, then pulses done.
module unidade_load_store #(
    parameter int unsigned END_MIN = 32'd128,
    parameter int unsigned END_MAX = 32'd223
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       erro,
    output logic [7:0] rdata,
    output logic       mem_write,
    output logic [7:0] mem_endereco,
    output logic [7:0] mem_dado_in,
    input  logic [7:0] mem_dado_out
);

    localparam logic [7:0] L_MIN = 8'(END_MIN);
    localparam logic [7:0] L_MAX = 8'(END_MAX);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        ESCRITA = 3'd1,
        LEITURA = 3'd2,
        CAPTURA = 3'd3,
        FIM     = 3'd4
    } estado_t;

    estado_t    r_estado;
    estado_t    w_prox_estado;
    logic       r_we;
    logic       r_erro;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic       w_em_faixa;
    logic       w_aceita;

    assign w_em_faixa   = (addr >= L_MIN) && (addr <= L_MAX);
    assign w_aceita     = (r_estado == OCIOSO) && req;
    assign rdata        = r_rdata;
    assign mem_endereco = r_addr;
    assign mem_dado_in  = r_wdata;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    // Request latch: captured only on acceptance so busy-time input activity is ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_erro  <= 1'b0;
            r_addr  <= 8'd0;
            r_wdata <= 8'd0;
        end else if (w_aceita) begin
            r_we    <= we;
            r_erro  <= ~w_em_faixa;
            r_addr  <= addr;
            r_wdata <= wdata;
        end else begin
            r_we    <= r_we;
            r_erro  <= r_erro;
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
        end
    end

    // Read-data register: only the closing edge of CAPTURA updates it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdata <= 8'd0;
        end else if (r_estado == CAPTURA) begin
            r_rdata <= mem_dado_out;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_prox_estado = r_estado;
        busy          = (r_estado != OCIOSO);
        done          = (r_estado == FIM);
        erro          = (r_estado == FIM) && r_erro;
        mem_write     = (r_estado == ESCRITA) && r_we && !r_erro;
        case (r_estado)
            OCIOSO: begin
                if (req) begin
                    if (!w_em_faixa) begin
                        w_prox_estado = FIM;
                    end else if (we) begin
                        w_prox_estado = ESCRITA;
                    end else begin
                        w_prox_estado = LEITURA;
                    end
                end else begin
                    w_prox_estado = OCIOSO;
                end
            end
            ESCRITA: w_prox_estado = FIM;
            LEITURA: w_prox_estado = CAPTURA;
            CAPTURA: w_prox_estado = FIM;
            FIM:     w_prox_estado = OCIOSO;
            default: w_prox_estado = OCIOSO;
        endcase
    end

endmodule

// File: tb/tb_unidade_load_store.sv
// Self-checking bench for unidade_load_store: vector table, continuous-request,
// busy-masking and mid-access reset sequences, checked through done/write scoreboards.
module tb_unidade_load_store;

    logic       clock = 1'b0;
    logic       reset;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       erro;
    logic [7:0] rdata;
    logic       mem_write;
    logic [7:0] mem_endereco;
    logic [7:0] mem_dado_in;
    logic [7:0] mem_dado_out;

    unidade_load_store #(.END_MIN(128), .END_MAX(223)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .erro(erro), .rdata(rdata),
        .mem_write(mem_write), .mem_endereco(mem_endereco),
        .mem_dado_in(mem_dado_in), .mem_dado_out(mem_dado_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       exp_erro;
        logic [7:0] exp_rdata;
    } vec_t;

    typedef struct {
        int         done_cyc;
        logic       erro;
        logic [7:0] rdata;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    exp_t       sb[$];
    wr_t        wq[$];
    logic [7:0] ram[256];
    int         cyc = 0;
    int         n_tot = 0;
    int         n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // RAM with registered read port
    always @(posedge clock) begin
        if (mem_write) ram[mem_endereco] <= mem_dado_in;
        mem_dado_out <= ram[mem_endereco];
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("erro", erro, e.erro);
                    chk("rdata", rdata, e.rdata);
                end
            end else begin
                chk("erro_without_done", erro, 1'b0);
            end
            if (mem_write) begin
                if (wq.size() == 0) begin
                    chk("spurious_write", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("write_cycle", cyc, w.cyc);
                    chk("write_addr", mem_endereco, w.a);
                    chk("write_data", mem_dado_in, w.d);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        #1;
    endtask

    // Called #1 after a posedge with the DUT idle; the request is accepted on the next edge.
    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic exp_e, input logic [7:0] exp_rd);
        int k;
        int lat;
        k   = cyc + 1;
        lat = exp_e ? 1 : (w ? 2 : 3);
        req = 1'b1; we = w; addr = a; wdata = d;
        sb.push_back('{k + lat - 1, exp_e, exp_rd});
        if (!exp_e && w) wq.push_back('{k, a, d});
        @(posedge clock); #1;
        req = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tab[11];
        int         next_acc;
        logic [7:0] cur_rd;

        tab[0]  = '{1'b1, 8'd150, 8'hA5, 1'b0, 8'h00};
        tab[1]  = '{1'b0, 8'd150, 8'h00, 1'b0, 8'hA5};
        tab[2]  = '{1'b0, 8'd127, 8'h00, 1'b1, 8'hA5};
        tab[3]  = '{1'b1, 8'd224, 8'h33, 1'b1, 8'hA5};
        tab[4]  = '{1'b1, 8'd128, 8'h11, 1'b0, 8'hA5};
        tab[5]  = '{1'b1, 8'd223, 8'h22, 1'b0, 8'hA5};
        tab[6]  = '{1'b0, 8'd128, 8'h00, 1'b0, 8'h11};
        tab[7]  = '{1'b0, 8'd223, 8'h00, 1'b0, 8'h22};
        tab[8]  = '{1'b0, 8'd0,   8'h00, 1'b1, 8'h22};
        tab[9]  = '{1'b1, 8'd255, 8'h44, 1'b1, 8'h22};
        tab[10] = '{1'b0, 8'd150, 8'h00, 1'b0, 8'hA5};

        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = 8'd0; wdata = 8'd0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_erro", erro, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_mem_endereco", mem_endereco, 8'h00);
        chk("rst_mem_dado_in", mem_dado_in, 8'h00);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++)
            issue(tab[i].we, tab[i].addr, tab[i].wdata, tab[i].exp_erro, tab[i].exp_rdata);
        chk("idle_busy", busy, 1'b0);
        chk("hold_endereco", mem_endereco, 8'd150);
        chk("hold_dado_in", mem_dado_in, 8'h00);
        cur_rd = 8'hA5;

        // Busy masking: one load of 150, inputs scrambled through LEITURA/CAPTURA/FIM.
        req = 1'b1; we = 1'b0; addr = 8'd150; wdata = 8'h00;
        sb.push_back('{cyc + 1 + 2, 1'b0, 8'hA5});
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            req   = 1'($urandom_range(1));
            we    = 1'b1;
            addr  = 8'($urandom_range(223, 128));
            wdata = 8'($urandom_range(255));
            @(posedge clock); #1;
        end
        req = 1'b0;
        wait_idle();
        repeat (3) @(posedge clock);
        #1;

        // Continuous req: four stores then four loads back to back.
        next_acc = cyc + 1;
        for (int i = 0; i < 8; i++) begin
            logic       w;
            logic [7:0] a;
            logic [7:0] d;
            int         lat;
            w   = (i < 4);
            a   = 8'(200 + (i % 4));
            d   = 8'(16 + (i % 4));
            lat = w ? 2 : 3;
            if (!w) cur_rd = d;
            req = 1'b1; we = w; addr = a; wdata = w ? d : 8'h00;
            sb.push_back('{next_acc + lat - 1, 1'b0, cur_rd});
            if (w) wq.push_back('{next_acc, a, d});
            while (cyc < next_acc) begin
                @(posedge clock); #1;
            end
            next_acc = next_acc + lat + 1;
        end
        req = 1'b0;
        wait_idle();

        // Reset during ESCRITA.
        req = 1'b1; we = 1'b1; addr = 8'd180; wdata = 8'h77;
        @(posedge clock); #1;
        req = 1'b0;
        chk("esc_mem_write_before", mem_write, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("esc_mem_write_reset", mem_write, 1'b0);
        chk("esc_busy_reset", busy, 1'b0);
        chk("esc_done_reset", done, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk("esc_no_ram_write", ram[180], 8'h00);

        // Reset during CAPTURA.
        req = 1'b1; we = 1'b0; addr = 8'd150; wdata = 8'h00;
        @(posedge clock); #1;
        req = 1'b0;
        @(posedge clock); #1;
        #2 reset = 1'b1;
        #1;
        chk("cap_rdata_reset", rdata, 8'h00);
        chk("cap_busy_reset", busy, 1'b0);
        chk("cap_done_reset", done, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        issue(1'b0, 8'd150, 8'h00, 1'b0, 8'hA5);

        repeat (3) @(posedge clock);
        #1;
        chk("sb_leftover", sb.size(), 32'd0);
        chk("wq_leftover", wq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/unidade_load_store.md
UNIDADE_LOAD_STORE -- requirements
Module: unidade_load_store

Interface
REQ-001 SHALL have parameter END_MIN, default 128: lowest valid data-RAM address.
REQ-002 SHALL have parameter END_MAX, default 223: highest valid data-RAM address.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 1: CPU access request; sampled only in OCIOSO.
REQ-006 SHALL have port we, input, 1: 1 = store, 0 = load; sampled with req.
REQ-007 SHALL have port addr, input, 8: CPU access address; sampled with req.
REQ-008 SHALL have port wdata, input, 8: store data; sampled with req.
REQ-009 SHALL have port busy, output, 1: high whenever state is not OCIOSO.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port erro, output, 1: address-range error; valid only while done is high.
REQ-012 SHALL have port rdata, output, 8: last successfully loaded byte.
REQ-013 SHALL have port mem_write, output, 1: write strobe to data RAM.
REQ-014 SHALL have port mem_endereco, output, 8: address to data RAM.
REQ-015 SHALL have port mem_dado_in, output, 8: write data to data RAM.
REQ-016 SHALL have port mem_dado_out, input, 8: registered read data from data RAM, valid one cycle after the address is presented with mem_write=0.

Function
REQ-017 SHALL implement FSM states OCIOSO, ESCRITA, LEITURA, CAPTURA, FIM.
REQ-018 In OCIOSO with req=1: SHALL latch we/addr/wdata into internal registers.
- In range (END_MIN <= addr <= END_MAX), store: go to ESCRITA.
- In range, load: go to LEITURA.
- Out of range: go to FIM with error flag set.
REQ-019 In OCIOSO with req=0: SHALL remain in OCIOSO.
REQ-020 ESCRITA SHALL last exactly one cycle: mem_write=1, mem_endereco=latched addr, mem_dado_in=latched wdata; then go to FIM.
REQ-021 LEITURA SHALL last one cycle: mem_write=0, mem_endereco=latched addr; then go to CAPTURA.
REQ-022 CAPTURA SHALL last one cycle: rdata loaded from mem_dado_out at the closing edge; then go to FIM.
REQ-023 FIM SHALL last one cycle with done=1 and erro equal to the latched error flag; then go to OCIOSO.
REQ-024 mem_write SHALL be 0 in every state except ESCRITA and SHALL never assert for an out-of-range address.
REQ-025 mem_endereco and mem_dado_in SHALL hold the latched values outside ESCRITA/LEITURA; no glitch to unrelated values.
REQ-026 Latency from the accepting edge k: store done high in cycle k+2; load done high in cycle k+3; error done high in cycle k+1.
REQ-027 rdata SHALL change only at the end of CAPTURA; stores and errored loads leave it unchanged.
REQ-028 req, we, addr and wdata SHALL be ignored while busy=1, including during FIM; the earliest next accept is the cycle after FIM.
REQ-029 A req held high continuously SHALL produce back-to-back accesses, one per FSM round-trip, with no lost or duplicated access.
REQ-030 Boundary addresses 128 and 223 SHALL be treated as in range; 127 and 224 SHALL be treated as errors.
REQ-031 erro SHALL be 0 whenever done is 0.

Reset
REQ-032 On reset=1, asynchronously and regardless of clock, the block SHALL:
- set state to OCIOSO;
- drive busy=0, done=0, erro=0, mem_write=0;
- set rdata=0, mem_endereco=0, mem_dado_in=0;
- clear all latched registers.
REQ-033 A reset asserted mid-access SHALL abort it: no done pulse, no further mem_write, and the first request after release is accepted normally.

Verification
REQ-034 Store then load: store addr=150 wdata=0xA5 -> mem_write=1 for one cycle at k+1 and done at k+2; then load addr=150 -> done at k+3, rdata=0xA5, erro=0.
REQ-035 Range check: load addr=127 and store addr=224 -> done at k+1 with erro=1, mem_write never high, rdata unchanged. Accesses at addr=128 and addr=223 -> erro=0.
REQ-036 Busy masking: toggle req/addr during ESCRITA, LEITURA, CAPTURA and FIM -> exactly one access executed, using the originally latched values.
REQ-037 Continuous req=1: alternate stores to 200..203 with data 0x10..0x13, then loads -> four done pulses per phase, loaded values 0x10..0x13 in order.
REQ-038 Reset mid-access: assert reset during ESCRITA -> mem_write drops immediately, no done; reset during CAPTURA -> rdata=0, no done; the next load after release completes normally.
